regfile_wb_arbiter: RTL

//  Shares the single register-file write port (writeReg/writeData/regWrite) between
//  two writeback sources: src0 = ALU result, src1 = memory load. Each source has a

---
 rtl/regfile_wb_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-source writeback arbiter for the register-file write port
//
// Purpose:
//   Merges two writeback sources onto the single register-file write port.
//   src0 carries ALU results and src1 carries memory loads.
//   Each source feeds a one-entry holding buffer through a valid/ready handshake.
//   An arbiter, round-robin or fixed priority, drains the buffers through a
//   three-state sequencer (IDLE -> SETUP -> PULSE). The register file commits on
//   transitions of regWrite, so writeReg/writeData are loaded one full cycle
//   before the strobe rises, and they hold while it is high.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous, active-high
//   src0_valid/ready/reg/data  ALU writeback handshake and payload
//   src1_valid/ready/reg/data  load writeback handshake and payload
//   writeReg, writeData      register-file write index and data (registered)
//   regWrite                 register-file write strobe, one-cycle pulse (registered)
//   busy                     sequencer active or a holding buffer occupied
//   wr_count                 completed write pulses, wraps at 16 bits

module regfile_wb_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src0_valid,
    output logic              src0_ready,
    input  logic [ADDR_W-1:0] src0_reg,
    input  logic [DATA_W-1:0] src0_data,
    input  logic              src1_valid,
    output logic              src1_ready,
    input  logic [ADDR_W-1:0] src1_reg,
    input  logic [DATA_W-1:0] src1_data,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              regWrite,
    output logic              busy,
    output logic [15:0]       wr_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;

    logic [1:0]        state;

    logic              buf0Full;
    logic [ADDR_W-1:0] buf0Reg;
    logic [DATA_W-1:0] buf0Data;
    logic              buf1Full;
    logic [ADDR_W-1:0] buf1Reg;
    logic [DATA_W-1:0] buf1Data;

    // Set when src1 should win the next tie; cleared at reset so src0 is favoured first.
    logic              rrFavour1;

    logic [15:0]       wrCount;

    logic              pick1;
    logic              grant0;
    logic              grant1;
    logic              anyGrant;
    logic [ADDR_W-1:0] grantReg;
    logic [DATA_W-1:0] grantData;

    // Arbitration. A grant is issued only in IDLE, so a full sequence costs three
    // cycles. Grants come straight from the buffer flags, which lets a granted
    // buffer take a new entry on the same edge.
    always_comb begin
        pick1     = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        anyGrant  = 1'b0;
        grantReg  = buf0Reg;
        grantData = buf0Data;

        if (FIXED_PRIO != 0) begin
            pick1 = buf1Full && !buf0Full;
        end else begin
            pick1 = buf1Full && (!buf0Full || rrFavour1);
        end

        if (state == IDLE) begin
            grant1 = pick1;
            grant0 = buf0Full && !pick1;
        end
        anyGrant = grant0 || grant1;

        if (grant1) begin
            grantReg  = buf1Reg;
            grantData = buf1Data;
        end
    end

    assign src0_ready = !buf0Full || grant0;
    assign src1_ready = !buf1Full || grant1;
    assign busy       = (state != IDLE) || buf0Full || buf1Full;
    assign wr_count   = wrCount;

    // Holding buffers. Acceptance takes precedence over grant-empty, so a buffer
    // that is drained and refilled on the same edge stays full with the new entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf0Full <= 1'b0;
            buf0Reg  <= '0;
            buf0Data <= '0;
            buf1Full <= 1'b0;
            buf1Reg  <= '0;
            buf1Data <= '0;
        end else begin
            if (src0_valid && src0_ready) begin
                buf0Full <= 1'b1;
                buf0Reg  <= src0_reg;
                buf0Data <= src0_data;
            end else if (grant0) begin
                buf0Full <= 1'b0;
            end

            if (src1_valid && src1_ready) begin
                buf1Full <= 1'b1;
                buf1Reg  <= src1_reg;
                buf1Data <= src1_data;
            end else if (grant1) begin
                buf1Full <= 1'b0;
            end
        end
    end

    // Round-robin pointer. Every grant moves it, including grants to r0 that
    // produce no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrFavour1 <= 1'b0;
        end else if (anyGrant) begin
            rrFavour1 <= grant0;
        end
    end

    // Write sequencer. The address and data are loaded only on the IDLE->SETUP
    // edge, so they are settled a full cycle before regWrite rises. A grant
    // targeting r0 drops the entry and stays in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            writeReg  <= '0;
            writeData <= '0;
            regWrite  <= 1'b0;
            wrCount   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    regWrite <= 1'b0;
                    if (anyGrant && (grantReg != '0)) begin
                        writeReg  <= grantReg;
                        writeData <= grantData;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    regWrite <= 1'b1;
                    state    <= PULSE;
                end
                PULSE: begin
                    regWrite <= 1'b0;
                    wrCount  <= wrCount + 16'd1;
                    state    <= IDLE;
                end
                default: begin
                    regWrite <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
